// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants, position type and small decode helpers.
// Consumers (the timing generator and the character renderer) take their
// defaults from here so the raster geometry is defined in one place.
package vga_timing_pkg;

    // Clock cycles per pixel: 100 MHz system clock -> 25 MHz pixel rate.
    localparam int unsigned VGA_CLK_DIV  = 4;

    // Horizontal timing in pixels.
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    // Vertical timing in lines.
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Inclusive sync windows, derived from the active and front-porch widths.
    localparam int unsigned VGA_H_SYNC_LO = VGA_H_ACTIVE + VGA_H_FP;
    localparam int unsigned VGA_H_SYNC_HI = VGA_H_SYNC_LO + VGA_H_SYNC - 1;
    localparam int unsigned VGA_V_SYNC_LO = VGA_V_ACTIVE + VGA_V_FP;
    localparam int unsigned VGA_V_SYNC_HI = VGA_V_SYNC_LO + VGA_V_SYNC - 1;

    // Raster counters are plain unsigned 10-bit values.
    localparam int unsigned CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    // A raster position, horizontal then vertical.
    typedef struct packed {
        cnt_t h;
        cnt_t v;
    } vga_pos_t;

    // True when val lies in the inclusive window [lo, hi].
    function automatic logic in_window(cnt_t val, cnt_t lo, cnt_t hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: divides clk down to a pixel strobe, walks the
// horizontal/vertical raster and presents a fully registered, self-consistent
// set of position, blanking and sync outputs, plus a per-frame frozen level.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV  = VGA_CLK_DIV,
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] level_in,
    output logic       pix_en,
    output logic [9:0] hcnt,
    output logic [9:0] vcnt,
    output logic       active,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output logic [4:0] level_out
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Divider width; a divide-by-one still needs a one-bit counter.
    localparam int unsigned DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [DivW-1:0] DivOne  = DivW'(1);

    localparam cnt_t HLast    = cnt_t'(H_TOTAL - 1);
    localparam cnt_t VLast    = cnt_t'(V_TOTAL - 1);
    localparam cnt_t HActive  = cnt_t'(H_ACTIVE);
    localparam cnt_t VActive  = cnt_t'(V_ACTIVE);
    localparam cnt_t HSyncLo  = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HSyncHi  = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam cnt_t VSyncLo  = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VSyncHi  = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam cnt_t CntOne   = cnt_t'(1);

    logic [DivW-1:0] div_q, div_d;
    logic            tick;

    // Position that the next tick will present. Keeping it separate from the
    // presented counters lets reset show (0,0) as idle and still have the
    // first tick after release present (0,0) rather than (1,0).
    vga_pos_t        nxt_q, nxt_d;
    logic            at_origin;

    cnt_t            hcnt_q, hcnt_d;
    cnt_t            vcnt_q, vcnt_d;
    logic            pix_en_q, pix_en_d;
    logic            frame_start_q, frame_start_d;
    logic            active_q, active_d;
    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic [4:0]      level_q, level_d;

    // Pixel clock divider: free-running 0..CLK_DIV-1, tick on the last count.
    always_comb begin
        tick  = (div_q == DivLast);
        div_d = tick ? '0 : div_q + DivOne;
    end

    // Raster walk: advance the upcoming position once per tick, wrapping both
    // axes on the same tick at the bottom-right corner.
    always_comb begin
        nxt_d     = nxt_q;
        at_origin = (nxt_q.h == '0) && (nxt_q.v == '0);
        if (tick) begin
            if (nxt_q.h == HLast) begin
                nxt_d.h = '0;
                nxt_d.v = (nxt_q.v == VLast) ? '0 : nxt_q.v + CntOne;
            end else begin
                nxt_d.h = nxt_q.h + CntOne;
            end
        end
    end

    // Output decode: on a tick every output moves to describe the same new
    // position; between ticks everything holds and the strobes drop.
    always_comb begin
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        active_d      = active_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        level_d       = level_q;
        pix_en_d      = tick;
        frame_start_d = 1'b0;
        if (tick) begin
            hcnt_d        = nxt_q.h;
            vcnt_d        = nxt_q.v;
            active_d      = (nxt_q.h < HActive) && (nxt_q.v < VActive);
            hsync_d       = !in_window(nxt_q.h, HSyncLo, HSyncHi);
            vsync_d       = !in_window(nxt_q.v, VSyncLo, VSyncHi);
            frame_start_d = at_origin;
            // Freeze the status level for the whole frame that starts here.
            if (at_origin) begin
                level_d = level_in;
            end
        end
    end

    // State and output registers; reset aborts any frame in progress at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= '0;
            nxt_q         <= '0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            pix_en_q      <= 1'b0;
            frame_start_q <= 1'b0;
            active_q      <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            level_q       <= '0;
        end else begin
            div_q         <= div_d;
            nxt_q         <= nxt_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            pix_en_q      <= pix_en_d;
            frame_start_q <= frame_start_d;
            active_q      <= active_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            level_q       <= level_d;
        end
    end

    assign pix_en      = pix_en_q;
    assign hcnt        = hcnt_q;
    assign vcnt        = vcnt_q;
    assign active      = active_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;
    assign level_out   = level_q;

endmodule
